// File: rtl/divisor_freq_prog_if.sv
// Control/status bundle for the programmable frequency divider.
// master drives the controls and reads the status; slave is the divider.
interface divisor_freq_prog_if #(
  parameter int WIDTH = 24
);
  logic             halt;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] div_value;
  logic             tick;
  logic             new_clock;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_active;

  modport master (
    output halt, load, step, div_value,
    input  tick, new_clock, count, div_active
  );

  modport slave (
    input  halt, load, step, div_value,
    output tick, new_clock, count, div_active
  );
endinterface

// File: rtl/divisor_freq_prog.sv
// Programmable frequency divider: counts 0..div_reg-1, pulses tick at the
// terminal count and toggles new_clock, giving a square wave of period
// 2*div_reg. Supports runtime divisor load, halt (freeze) and, when the
// macro DIVISOR_FREQ_STEP_EN is defined, single-stepping while halted.
module divisor_freq_prog #(
  parameter int WIDTH       = 24,
  parameter int DEFAULT_DIV = 12500000
) (
  input  logic                 clock_fpga,
  input  logic                 congela,
  divisor_freq_prog_if.slave   bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic             tick_q,  tick_d;
  logic             nclk_q,  nclk_d;
  logic             term;

  // div_q is never 0 (reset value is legal and loads clamp 0 to 1), so
  // div_q-1 never underflows and count can never run past it.
  assign term = (count_q == (div_q - WIDTH'(1)));

`ifdef DIVISOR_FREQ_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise = bus.step & ~step_q;

  // Edge detector on step so a held request produces a single advance.
  always_ff @(posedge clock_fpga) begin
    if (congela) step_q <= 1'b0;
    else         step_q <= bus.step;
  end
`else
  logic unused_step;
  assign unused_step = bus.step;
`endif

  // Next-state: load beats halt/step, which beat normal counting.
  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    nclk_d  = nclk_q;
    if (bus.load) begin
      div_d   = (bus.div_value == '0) ? WIDTH'(1) : bus.div_value;
      count_d = '0;
    end else if (bus.halt) begin
`ifdef DIVISOR_FREQ_STEP_EN
      if (step_rise) begin
        tick_d  = 1'b1;
        nclk_d  = ~nclk_q;
        count_d = '0;
      end
`endif
    end else if (term) begin
      count_d = '0;
      tick_d  = 1'b1;
      nclk_d  = ~nclk_q;
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // State registers with synchronous reset to the default divisor.
  always_ff @(posedge clock_fpga) begin
    if (congela) begin
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      tick_q  <= 1'b0;
      nclk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      nclk_q  <= nclk_d;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.new_clock  = nclk_q;
  assign bus.count      = count_q;
  assign bus.div_active = div_q;

endmodule

// File: tb/tb_divisor_freq_prog.sv
// Self-checking bench for divisor_freq_prog: directed scenarios with literal
// expectations plus randomized control traffic compared every cycle against
// a behavioural phase/modulo model.
module tb_divisor_freq_prog;
  localparam int W    = 8;
  localparam int DDIV = 4;

  logic clk = 1'b0;
  logic congela;
  divisor_freq_prog_if #(.WIDTH(W)) bus ();

  divisor_freq_prog #(.WIDTH(W), .DEFAULT_DIV(DDIV)) dut (
    .clock_fpga (clk),
    .congela    (congela),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  int m_phase, m_div;
  bit m_tick, m_nclk, m_stp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase advances modulo the divisor; a wrap to 0 is a tick.
  always @(posedge clk) begin
    if (congela) begin
      m_phase = 0; m_div = DDIV; m_tick = 0; m_nclk = 0;
    end else if (bus.load) begin
      m_div   = (bus.div_value == 0) ? 1 : int'(bus.div_value);
      m_phase = 0; m_tick = 0;
    end else if (bus.halt) begin
      m_tick = 0;
`ifdef DIVISOR_FREQ_STEP_EN
      if (bus.step && !m_stp) begin
        m_tick = 1; m_nclk = !m_nclk; m_phase = 0;
      end
`endif
    end else begin
      m_phase = (m_phase + 1) % m_div;
      m_tick  = (m_phase == 0);
      if (m_tick) m_nclk = !m_nclk;
    end
    m_stp = congela ? 1'b0 : bus.step;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_tick",  32'(bus.tick),       32'(m_tick));
      chk("model_nclk",  32'(bus.new_clock),  32'(m_nclk));
      chk("model_count", 32'(bus.count),      32'(m_phase));
      chk("model_div",   32'(bus.div_active), 32'(m_div));
      if (m_div > 0)
        chk("count_lt_div", 32'(bus.count < bus.div_active), 32'd1);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ntick;
    bit n0;
    congela = 1'b1;
    bus.halt = 0; bus.load = 0; bus.step = 0; bus.div_value = '0;
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_tick",  32'(bus.tick), 0);
    chk("rst_nclk",  32'(bus.new_clock), 0);
    chk("rst_div",   32'(bus.div_active), DDIV);

    // Free run with default divisor 4
    congela = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk("run_tick",  32'(bus.tick), 32'(i % 4 == 0));
      chk("run_count", 32'(bus.count), 32'(i % 4));
      chk("run_nclk",  32'(bus.new_clock), 32'((i / 4) % 2));
    end

    // Load 3 at count 2: no tick on the load edge, then every 3 cycles
    cyc(2);
    chk("pre_load_count", 32'(bus.count), 2);
    bus.load = 1; bus.div_value = 3;
    cyc();
    bus.load = 0;
    chk("load3_count", 32'(bus.count), 0);
    chk("load3_tick",  32'(bus.tick), 0);
    chk("load3_div",   32'(bus.div_active), 3);
    chk("load3_nclk",  32'(bus.new_clock), 1);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("div3_tick", 32'(bus.tick), 32'(i % 3 == 0));
    end

    // Halt at count 2 for 10 cycles, resume with next tick 2 cycles later
    bus.load = 1; bus.div_value = 4;
    cyc();
    bus.load = 0;
    cyc(2);
    bus.halt = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("halt_count", 32'(bus.count), 2);
      chk("halt_tick",  32'(bus.tick), 0);
    end
    bus.halt = 0;
    cyc();
    chk("resume1_tick", 32'(bus.tick), 0);
    chk("resume1_count", 32'(bus.count), 3);
    cyc();
    chk("resume2_tick", 32'(bus.tick), 1);

    // Load 0 clamps to 1: continuous tick, new_clock toggles each cycle
    bus.load = 1; bus.div_value = 0;
    cyc();
    bus.load = 0;
    chk("load0_div",  32'(bus.div_active), 1);
    chk("load0_tick", 32'(bus.tick), 0);
    n0 = bus.new_clock;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("div1_tick", 32'(bus.tick), 1);
      chk("div1_nclk", 32'(bus.new_clock), 32'(n0 ^ i[0]));
    end

    // Reset mid-period after loading 7
    bus.load = 1; bus.div_value = 7;
    cyc();
    bus.load = 0;
    cyc(3);
    chk("pre_rst_count", 32'(bus.count), 3);
    congela = 1;
    cyc();
    congela = 0;
    chk("mrst_count", 32'(bus.count), 0);
    chk("mrst_div",   32'(bus.div_active), DDIV);
    chk("mrst_nclk",  32'(bus.new_clock), 0);
    chk("mrst_tick",  32'(bus.tick), 0);

    // Step held high while halted
    cyc();
    bus.halt = 1;
    cyc();
    bus.step = 1;
    ntick = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      ntick += int'(bus.tick);
    end
`ifdef DIVISOR_FREQ_STEP_EN
    chk("step_ticks", 32'(ntick), 1);
    chk("step_count", 32'(bus.count), 0);
    chk("step_nclk",  32'(bus.new_clock), 1);
`else
    chk("step_ticks", 32'(ntick), 0);
    chk("step_count", 32'(bus.count), 1);
    chk("step_nclk",  32'(bus.new_clock), 0);
`endif
    bus.step = 0; bus.halt = 0;
    cyc();
    bus.step = 1;
    cyc(5);
    bus.step = 0;

    // Randomized control traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      congela = ($urandom_range(0, 199) == 0);
      bus.load = ($urandom_range(0, 19) == 0);
      bus.div_value = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                  : W'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) bus.halt = ~bus.halt;
      bus.step = ($urandom_range(0, 3) == 0) ? ~bus.step : bus.step;
      cyc();
    end
    congela = 0; bus.load = 0; bus.halt = 0; bus.step = 0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divisor_freq_prog.md
DIVISOR_FREQ_PROG -- requirements
Module: divisor_freq_prog

Interface
REQ-001 Parameter WIDTH, default 24, bit width of the divisor and counter.
REQ-002 Parameter DEFAULT_DIV, default 12500000, divisor value loaded at reset; SHALL be in 1..2^WIDTH-1.
REQ-003 clock_fpga  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 congela  input  1  reset; synchronous, active-high.
REQ-005 halt  input  1  freeze: while high, the counter and outputs SHALL hold.
REQ-006 load  input  1  single-cycle request to latch div_value.
REQ-007 div_value  input  WIDTH  new divisor, sampled when load=1.
REQ-008 step  input  1  single-step request, honoured only while halt=1 (see Configuration).
REQ-009 tick  output  1  registered one-cycle pulse, once per divisor period.
REQ-010 new_clock  output  1  registered square wave; toggles on every tick; period 2*div_reg cycles.
REQ-011 count  output  WIDTH  current counter value.
REQ-012 div_active  output  WIDTH  divisor currently in use (div_reg).

Function
REQ-013 div_reg SHALL be a WIDTH-bit register holding the active divisor.
REQ-014 When running (halt=0, load=0), count SHALL advance 0,1,...,div_reg-1 and then wrap to 0.
REQ-015 On the edge where count==div_reg-1, the block SHALL set count<=0, tick<=1 and new_clock<=~new_clock.
- On all other running edges, tick<=0.
REQ-016 With div_reg=1, tick SHALL stay high every cycle and new_clock SHALL toggle every cycle.
REQ-017 load=1 SHALL latch div_value into div_reg, set count<=0 and tick<=0, and hold new_clock.
- div_value=0 SHALL be clamped to 1.
- The new period starts counting on the next edge.
REQ-018 load SHALL take priority over halt, step and the terminal-count event.
- If load coincides with count==div_reg-1, no tick is produced.
REQ-019 While halt=1 and load=0, count, new_clock and div_reg SHALL hold, and tick SHALL be 0.
- Exception: a single-step event (REQ-027).
REQ-020 Deasserting halt SHALL resume counting from the held count value with no extra tick.
REQ-021 After a runtime load, count SHALL never exceed div_reg-1.
REQ-022 Priority order: congela > load > halt/step > normal counting.
REQ-023 Arithmetic: count+1 SHALL be computed in WIDTH bits; wrap beyond div_reg-1 SHALL be impossible by construction.

Reset
REQ-024 On a clock edge with congela=1, the block SHALL set:
- count<=0
- tick<=0
- new_clock<=0
- div_reg<=DEFAULT_DIV
- the step edge-detect register <=0
REQ-025 Reset asserted mid-period SHALL discard the partial count; the first tick after release SHALL occur exactly DEFAULT_DIV cycles after the first edge with congela=0.
REQ-026 Outputs SHALL be defined (no X) from the first edge with congela=1.

Configuration
REQ-027 Macro DIVISOR_FREQ_STEP_EN defined:
- A registered rising-edge detector on step SHALL be present.
- A step rising edge while halt=1 and load=0 SHALL produce exactly one tick pulse (one cycle), toggle new_clock and set count<=0.
- A step edge while halt=0 SHALL be ignored.
- Holding step high SHALL produce only one tick.
REQ-028 Macro DIVISOR_FREQ_STEP_EN undefined:
- The step input SHALL be ignored.
- No step edge-detect logic SHALL exist.
- Halt behaves strictly per REQ-019.

Verification
REQ-029 Reset with DEFAULT_DIV=4, halt=0, run 20 cycles -> tick high in cycles 4, 8, 12, 16, 20 after release; new_clock period 8; count sequence 0..3 repeating.
REQ-030 load with div_value=3 at count=2 (div 4) -> count=0 next cycle, no tick that cycle, ticks every 3 cycles afterwards, div_active=3.
REQ-031 load with div_value=0 -> div_active=1, tick continuously high from the 2nd cycle, new_clock toggling every cycle.
REQ-032 halt raised at count=2 (div 4) for 10 cycles, then released -> count held at 2, tick=0 throughout, next tick 2 cycles after release.
REQ-033 DIVISOR_FREQ_STEP_EN defined, halt=1, step held high for 5 cycles -> exactly one tick, new_clock toggled once, count=0; repeat with halt=0 -> no extra tick; macro undefined -> no tick.
REQ-034 congela asserted for 1 cycle at count=3 after load of 7 -> count=0, div_active=DEFAULT_DIV, new_clock=0, tick=0 on the next cycle.
